ring_shift_collector: RTL and testbench

- Receive-side counterpart to the team's ring shift register, which emits an S*N-bit word as S slices of N bits, LSB slice first.
- This block captures N-bit slices arriving one per accepted cycle, typically from the output edge of the systolic array.
- It reassembles them into an S*N-bit word and presents the word to downstream logic with a valid/ready handshake.
- It stalls the producer while a completed word has not yet been consumed.

---
 rtl/ring_shift_collector_pkg.sv | 27 ++
 rtl/ring_shift_collector_slice_counter.sv | 34 +++
 rtl/ring_shift_collector.sv | 134 +++++++++++++
 tb/tb_ring_shift_collector.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ring_shift_collector_pkg.sv
// Shared definitions for the ring shift collector: state encoding, counter
// width derivation and the slice-index-to-bit-range helpers that the ring
// shift register's bench uses as well.
package ring_shift_collector_pkg;

    // Collector states: FILL gathers slices, FULL holds a finished word.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    // Width needed to represent a slice count from 0 up to and including s.
    function automatic int calc_cw(input int s);
        return $clog2(s + 1);
    endfunction

    // Lowest bit of slice k in a word built from n-bit slices.
    function automatic int slice_lo(input int k, input int n);
        return k * n;
    endfunction

    // Highest bit of slice k in a word built from n-bit slices.
    function automatic int slice_hi(input int k, input int n);
        return k * n + n - 1;
    endfunction

endpackage

// File: rtl/ring_shift_collector_slice_counter.sv
// Saturating 0..S slice counter. Clear beats load-to-1, which beats
// increment; the count never moves past S.
module slice_counter
    import ring_shift_collector_pkg::*;
#(
    parameter int S  = 8,
    parameter int CW = calc_cw(S)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_load1,
    input  logic          i_inc,
    output logic [CW-1:0] o_count
);

    logic [CW-1:0] r_count;

    // Count register with clear / load-to-1 / saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= CW'(1);
        end else if (i_inc && (r_count != CW'(S))) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ring_shift_collector.sv
// Receive side of the ring shift register: collects N-bit slices LSB slice
// first into an S*N-bit word and hands it downstream with valid/ready.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both 1. in_ready never depends on in_valid; it is 1 in FILL, follows
// out_ready in FULL (so a slice can enter in the same cycle the old word
// leaves) and is 0 whenever clear is high. out_valid depends only on state.
module ring_shift_collector
    import ring_shift_collector_pkg::*;
#(
    parameter int  N  = 2,
    parameter int  S  = 8,
    localparam int CW = calc_cw(S)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           in_valid,
    input  logic [N-1:0]   in_data,
    output logic           in_ready,
    output logic           out_valid,
    output logic [S*N-1:0] out_data,
    input  logic           out_ready,
    output logic [CW-1:0]  count,
    output logic           dbg_state
);

    state_e         r_state;
    state_e         w_state_next;
    logic [S*N-1:0] r_shift;
    logic [S*N-1:0] w_shift_next;
    logic [CW-1:0]  w_count;
    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_accept;
    logic           w_last;
    logic           w_cnt_clear;
    logic           w_cnt_load1;
    logic           w_cnt_inc;

    assign w_last   = (w_count == CW'(S - 1));
    assign w_accept = in_valid && w_in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, handshake outputs and counter controls; clear overrides all.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_cnt_clear  = 1'b0;
        w_cnt_load1  = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_cnt_inc = 1'b1;
                    if (w_last) begin
                        w_state_next = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                w_out_valid = 1'b1;
                w_in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        // The incoming slice is slice 0 of the next word; with
                        // a single-slice word it completes that word at once.
                        w_cnt_load1  = 1'b1;
                        w_state_next = (S == 1) ? ST_FULL : ST_FILL;
                    end else begin
                        w_cnt_clear  = 1'b1;
                        w_state_next = ST_FILL;
                    end
                end
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
        if (clear) begin
            w_in_ready   = 1'b0;
            w_cnt_clear  = 1'b1;
            w_cnt_load1  = 1'b0;
            w_cnt_inc    = 1'b0;
            w_state_next = ST_FILL;
        end
    end

    // New slice enters at the top so the first slice ends up in the low bits.
    always_comb begin
        w_shift_next = r_shift >> N;
        w_shift_next[slice_lo(S - 1, N) +: N] = in_data;
    end

    // Word register: zeroed by clear, shifted on every accepted slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (clear) begin
            r_shift <= '0;
        end else if (w_accept) begin
            r_shift <= w_shift_next;
        end
    end

    slice_counter #(
        .S  (S),
        .CW (CW)
    ) u_slice_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_cnt_clear),
        .i_load1 (w_cnt_load1),
        .i_inc   (w_cnt_inc),
        .o_count (w_count)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_shift;
    assign count     = w_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ring_shift_collector.sv
// Directed bench for ring_shift_collector with N=2, S=8.
module tb_ring_shift_collector;

    localparam int N  = 2;
    localparam int S  = 8;
    localparam int W  = S * N;
    localparam int CW = $clog2(S + 1);

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          dbg_state;

    always #5 clk = ~clk;

    ring_shift_collector #(.N(N), .S(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_word(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got 0x%0h expected <empty queue>", tag, out_data);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, 32'(out_data), 32'(e));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  t1 [8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [1:0]  t4 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [15:0] tx_reg;
    logic        en;

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_count",     32'(count),     32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_state",     32'(dbg_state), 32'd0);
        #10 rst_n = 1'b1;
        step();

        // 1: fill with backpressure
        exp_q.push_back(16'h1B1B);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = t1[i];
            step();
            check_eq("t1_count",     32'(count),     32'(i + 1));
            check_eq("t1_out_valid", 32'(out_valid), 32'(i == 7));
        end
        in_data = 2'd2;
        #1;
        check_eq("t1_in_ready_held", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t1_hold_data",  32'(out_data),  32'h1B1B);
            check_eq("t1_hold_count", 32'(count),     32'd8);
            check_eq("t1_hold_valid", 32'(out_valid), 32'd1);
        end
        check_word("t1_word");

        // 2: back-to-back words, first accept also consumes 0x1B1B
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 2'b01;
        exp_q.push_back(16'h5555);
        exp_q.push_back(16'h5555);
        for (int i = 1; i <= 16; i++) begin
            step();
            check_eq("t2_count",     32'(count),     32'(((i - 1) % 8) + 1));
            check_eq("t2_out_valid", 32'(out_valid), 32'(i % 8 == 0));
            check_eq("t2_in_ready",  32'(in_ready),  32'd1);
            if (i % 8 == 0) check_word("t2_word");
        end
        in_valid = 1'b0;
        step();
        check_eq("t2_drain_count", 32'(count),     32'd0);
        check_eq("t2_drain_valid", 32'(out_valid), 32'd0);

        // 3: gapped input, junk data on idle cycles
        out_ready = 1'b0;
        exp_q.push_back(16'h9999);
        for (int c = 1; c <= 15; c++) begin
            in_valid = (c % 2 == 1);
            in_data  = in_valid ? ((((c - 1) / 2) % 2 == 0) ? 2'd1 : 2'd2) : 2'd3;
            step();
            check_eq("t3_count",     32'(count),     32'((c + 1) / 2));
            check_eq("t3_out_valid", 32'(out_valid), 32'(c == 15));
        end
        check_word("t3_word");
        check_eq("t3_low_slice",  32'(out_data[1:0]),   32'd1);
        check_eq("t3_high_slice", 32'(out_data[15:14]), 32'd2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("t3_drain_valid", 32'(out_valid), 32'd0);

        // 4: clear mid-word
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 2'd3;
            step();
        end
        check_eq("t4_count5", 32'(count), 32'd5);
        clear    = 1'b1;
        in_data  = 2'd2;
        #1;
        check_eq("t4_clear_in_ready", 32'(in_ready), 32'd0);
        step();
        clear = 1'b0;
        check_eq("t4_clear_count", 32'(count),     32'd0);
        check_eq("t4_clear_valid", 32'(out_valid), 32'd0);
        check_eq("t4_clear_data",  32'(out_data),  32'd0);
        exp_q.push_back(16'hE4E4);
        for (int i = 0; i < 8; i++) begin
            in_data = t4[i];
            step();
        end
        check_eq("t4_count8", 32'(count),     32'd8);
        check_eq("t4_valid",  32'(out_valid), 32'd1);
        check_word("t4_word");

        // 5: asynchronous reset while FULL
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_valid", 32'(out_valid), 32'd0);
        check_eq("t5_async_count", 32'(count),     32'd0);
        check_eq("t5_async_data",  32'(out_data),  32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check_eq("t5_in_ready", 32'(in_ready),  32'd1);
        check_eq("t5_state",    32'(dbg_state), 32'd0);
        check_eq("t5_count",    32'(count),     32'd0);

        // 6: round trip from a modelled transmitter, one disabled cycle
        tx_reg = 16'hC3A5;
        exp_q.push_back(16'hC3A5);
        for (int c = 0; c < 9; c++) begin
            en       = (c != 3);
            in_valid = en;
            in_data  = tx_reg[1:0];
            step();
            if (en) tx_reg = tx_reg >> 2;
            check_eq("t6_out_valid", 32'(out_valid), 32'(c == 8));
        end
        check_word("t6_word");
        check_eq("t6_state", 32'(dbg_state), 32'd1);

        // 7: clear in FULL beats a pending handoff
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 2'd3;
        clear     = 1'b1;
        #1;
        check_eq("t7_in_ready", 32'(in_ready), 32'd0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check_eq("t7_valid", 32'(out_valid), 32'd0);
        check_eq("t7_count", 32'(count),     32'd0);
        check_eq("t7_data",  32'(out_data),  32'd0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL leftover_words: got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
